// File: rtl/dbg_pkg.sv
// ---------------------------------------------------------------
// dbg_pkg : shared types for the debug run-control block
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package dbg_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } dbg_state_t;

  localparam int PC_W = 9;

  typedef struct packed {
    logic            en;
    logic [PC_W-1:0] addr;
  } bp_slot_t;

  function automatic int idx_width(input int n);
    return $clog2(n) | 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dbg_bp_cmp.sv
// ---------------------------------------------------------------
// dbg_bp_cmp : breakpoint slot storage with lowest-index-wins PC match
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module dbg_bp_cmp
  import dbg_pkg::*;
#(
  parameter int NUM_BP = 2,
  parameter int IDX_W  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  pc,
  input  logic             bp_wr,
  input  logic [IDX_W-1:0] bp_idx,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_en,
  output logic             match,
  output logic [IDX_W-1:0] idx
);

  bp_slot_t r_slots [NUM_BP];

  // Out-of-range indices never equal any slot number, so such writes drop out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BP; i++) begin
        r_slots[i] <= '0;
      end
    end else if (bp_wr) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (bp_idx == IDX_W'(i)) begin
          r_slots[i] <= '{en: bp_en, addr: bp_addr};
        end
      end
    end
  end

  // Scan from the top so the lowest matching slot is the last one written.
  always_comb begin
    match = 1'b0;
    idx   = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (r_slots[i].en && (r_slots[i].addr == pc)) begin
        match = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dbg_run_ctrl.sv
// ---------------------------------------------------------------
// dbg_run_ctrl : halt/step/resume sequencer driving the PC freeze, with PC breakpoints
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module dbg_run_ctrl #(
  parameter int  PC_W   = 9,
  parameter int  STEP_W = 8,
  parameter int  NUM_BP = 2,
  localparam int IDX_W  = dbg_pkg::idx_width(NUM_BP)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   pc,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              resume_req,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_count,
  input  logic              bp_wr,
  input  logic [IDX_W-1:0]  bp_idx,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic              bp_en,
  output logic              enable_debug,
  output logic              halted,
  output logic              bp_hit,
  output logic [IDX_W-1:0]  hit_idx,
  output logic [STEP_W-1:0] steps_left
);

  import dbg_pkg::*;

  dbg_state_t        r_state,   w_state_nxt;
  logic [STEP_W-1:0] r_steps,   w_steps_nxt;
  logic              r_skip,    w_skip_nxt;
  logic              r_bp_hit,  w_bp_hit_nxt;
  logic [IDX_W-1:0]  r_hit_idx, w_hit_idx_nxt;

  logic              w_cmp_match;
  logic [IDX_W-1:0]  w_cmp_idx;
  logic              w_bp_match;
  logic              w_running;
  logic              w_freeze;
  logic              w_advance;
  logic              w_leave_halt;

  dbg_bp_cmp #(
    .NUM_BP (NUM_BP),
    .IDX_W  (IDX_W)
  ) u_bp_cmp (
    .clk     (clk),
    .reset   (reset),
    .pc      (pc),
    .bp_wr   (bp_wr),
    .bp_idx  (bp_idx),
    .bp_addr (bp_addr),
    .bp_en   (bp_en),
    .match   (w_cmp_match),
    .idx     (w_cmp_idx)
  );

  // Combinational freeze keeps the PC parked on the breakpoint address itself.
  assign w_bp_match = w_cmp_match & ~r_skip;
  assign w_running  = (r_state == RUN) | (r_state == STEP);
  assign w_freeze   = (r_state == HALTED) | (w_running & w_bp_match);
  assign w_advance  = ~w_freeze & ~stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RUN;
      r_steps   <= '0;
      r_skip    <= 1'b0;
      r_bp_hit  <= 1'b0;
      r_hit_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_steps   <= w_steps_nxt;
      r_skip    <= w_skip_nxt;
      r_bp_hit  <= w_bp_hit_nxt;
      r_hit_idx <= w_hit_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_steps_nxt   = r_steps;
    w_bp_hit_nxt  = r_bp_hit;
    w_hit_idx_nxt = r_hit_idx;
    w_leave_halt  = 1'b0;

    case (r_state)
      RUN: begin
        if (halt_req | w_bp_match) begin
          w_state_nxt = HALTED;
        end
      end
      HALTED: begin
        if (resume_req) begin
          w_state_nxt  = RUN;
          w_leave_halt = 1'b1;
        end else if (step_req && (step_count != '0)) begin
          w_state_nxt  = STEP;
          w_steps_nxt  = step_count;
          w_leave_halt = 1'b1;
        end
      end
      STEP: begin
        if (halt_req | w_bp_match) begin
          w_state_nxt = HALTED;
          w_steps_nxt = '0;
        end else if (resume_req) begin
          w_state_nxt = RUN;
          w_steps_nxt = '0;
        end else if (w_advance) begin
          // Halting on the final load's edge gives exactly N PC updates.
          if (r_steps <= STEP_W'(1)) begin
            w_state_nxt = HALTED;
            w_steps_nxt = '0;
          end else begin
            w_steps_nxt = r_steps - STEP_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_steps_nxt = '0;
      end
    endcase

    if (w_leave_halt) begin
      w_bp_hit_nxt  = 1'b0;
      w_hit_idx_nxt = '0;
    end
    if (w_running && w_bp_match) begin
      w_bp_hit_nxt  = 1'b1;
      w_hit_idx_nxt = w_cmp_idx;
    end

    // Skip lets the first instruction after leaving HALTED step off a breakpoint.
    if (w_leave_halt) begin
      w_skip_nxt = 1'b1;
    end else if (w_advance | halt_req) begin
      w_skip_nxt = 1'b0;
    end else begin
      w_skip_nxt = r_skip;
    end
  end

  assign enable_debug = w_freeze;
  assign halted       = (r_state == HALTED);
  assign bp_hit       = r_bp_hit;
  assign hit_idx      = r_hit_idx;
  assign steps_left   = r_steps;

endmodule

`default_nettype wire

// File: tb/tb_dbg_run_ctrl.sv
// ---------------------------------------------------------------
// tb_dbg_run_ctrl : vector table, directed corner sequences and random run vs reference model
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_dbg_run_ctrl;

  localparam int PC_W   = 9;
  localparam int STEP_W = 8;
  localparam int NUM_BP = 2;
  localparam int IDX_W  = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [PC_W-1:0]   pc;
  logic              stall, halt_req, resume_req, step_req;
  logic [STEP_W-1:0] step_count;
  logic              bp_wr;
  logic [IDX_W-1:0]  bp_idx;
  logic [PC_W-1:0]   bp_addr;
  logic              bp_en;
  logic              enable_debug, halted, bp_hit;
  logic [IDX_W-1:0]  hit_idx;
  logic [STEP_W-1:0] steps_left;

  always #5 clk = ~clk;

  dbg_run_ctrl #(.PC_W(PC_W), .STEP_W(STEP_W), .NUM_BP(NUM_BP)) dut (
    .clk(clk), .reset(reset), .pc(pc), .stall(stall),
    .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req), .step_count(step_count),
    .bp_wr(bp_wr), .bp_idx(bp_idx), .bp_addr(bp_addr), .bp_en(bp_en),
    .enable_debug(enable_debug), .halted(halted), .bp_hit(bp_hit),
    .hit_idx(hit_idx), .steps_left(steps_left)
  );

  // Stand-in for the PC register: increments whenever it is allowed to load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= '0;
    else if (!enable_debug && !stall) pc <= pc + 1'b1;
  end

  typedef struct {
    bit halt; bit resume; bit step; int cnt; bit stall;
    bit wr; int widx; int waddr; bit wen;
  } stim_t;

  typedef struct {
    bit halt; bit resume; bit step; int cnt; bit stall;
    bit en; bit hlt; int steps;
  } vec_t;

  typedef enum {M_RUN, M_HALT, M_STEP} mmode_t;

  int     n_cmp, n_fail;
  mmode_t m_mode;
  int     m_rem, m_hidx;
  bit     m_skip, m_hit;
  bit     m_en   [NUM_BP];
  int     m_addr [NUM_BP];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic int m_first_hit();
    if (m_skip) return -1;
    for (int i = 0; i < NUM_BP; i++)
      if (m_en[i] && m_addr[i] == int'(pc)) return i;
    return -1;
  endfunction

  function automatic bit m_freeze();
    return (m_mode == M_HALT) || (m_mode != M_HALT && m_first_hit() >= 0);
  endfunction

  task automatic m_reset();
    m_mode = M_RUN; m_rem = 0; m_skip = 0; m_hit = 0; m_hidx = 0;
    for (int i = 0; i < NUM_BP; i++) begin m_en[i] = 0; m_addr[i] = 0; end
  endtask

  task automatic m_next(input stim_t s);
    int     h;
    bit     adv, left;
    mmode_t old;
    h = m_first_hit(); adv = !m_freeze() && !s.stall; left = 0; old = m_mode;
    case (m_mode)
      M_RUN:  if (s.halt || h >= 0) m_mode = M_HALT;
      M_HALT: if (s.resume) begin m_mode = M_RUN; left = 1; end
              else if (s.step && s.cnt != 0) begin m_mode = M_STEP; m_rem = s.cnt; left = 1; end
      M_STEP: if (s.halt || h >= 0) begin m_mode = M_HALT; m_rem = 0; end
              else if (s.resume) begin m_mode = M_RUN; m_rem = 0; end
              else if (adv) begin m_rem = m_rem - 1; if (m_rem == 0) m_mode = M_HALT; end
      default: m_mode = M_RUN;
    endcase
    if (left) begin m_hit = 0; m_hidx = 0; end
    if (old != M_HALT && h >= 0) begin m_hit = 1; m_hidx = h; end
    if (left) m_skip = 1;
    else if (adv || s.halt) m_skip = 0;
    if (s.wr && s.widx < NUM_BP) begin m_en[s.widx] = s.wen; m_addr[s.widx] = s.waddr; end
  endtask

  task automatic drive(input stim_t s);
    halt_req = s.halt; resume_req = s.resume; step_req = s.step;
    step_count = STEP_W'(s.cnt); stall = s.stall;
    bp_wr = s.wr; bp_idx = IDX_W'(s.widx); bp_addr = PC_W'(s.waddr); bp_en = s.wen;
  endtask

  task automatic compare_all();
    check("enable_debug", {31'd0, enable_debug}, {31'd0, m_freeze()});
    check("halted",       {31'd0, halted},       {31'd0, (m_mode == M_HALT)});
    check("bp_hit",       {31'd0, bp_hit},       {31'd0, m_hit});
    check("hit_idx",      {31'd0, hit_idx},      m_hidx);
    check("steps_left",   {24'd0, steps_left},   m_rem);
  endtask

  task automatic apply(input stim_t s);
    drive(s);
    #1;
  endtask

  task automatic finish_cyc(input stim_t s);
    compare_all();
    m_next(s);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick(input stim_t s);
    apply(s);
    finish_cyc(s);
  endtask

  task automatic do_reset();
    drive(idle());
    reset = 1'b1;
    m_reset();
    #1;
    compare_all();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_to(input int addr, output bit found);
    found = 0;
    for (int k = 0; k < 600; k++) begin
      apply(idle());
      if (int'(pc) == addr) begin found = 1; break; end
      finish_cyc(idle());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t  tbl [9];
    stim_t s;
    bit    found;
    int    pc_mark;

    n_cmp = 0; n_fail = 0; pc_mark = 0;
    tbl[0] = '{0,0,0,0,0, 0,0,0};
    tbl[1] = '{1,0,0,0,0, 0,0,0};
    tbl[2] = '{0,0,0,0,0, 1,1,0};
    tbl[3] = '{0,0,1,3,0, 1,1,0};
    tbl[4] = '{0,0,0,0,0, 0,0,3};
    tbl[5] = '{0,0,0,0,1, 0,0,2};
    tbl[6] = '{0,0,0,0,0, 0,0,2};
    tbl[7] = '{0,0,0,0,0, 0,0,1};
    tbl[8] = '{0,0,0,0,0, 1,1,0};

    drive(idle());
    @(negedge clk);
    do_reset();

    // Halt, then a 3-step run with a stall on the second step.
    for (int r = 0; r < 9; r++) begin
      s = idle();
      s.halt = tbl[r].halt; s.resume = tbl[r].resume; s.step = tbl[r].step;
      s.cnt = tbl[r].cnt; s.stall = tbl[r].stall;
      apply(s);
      if (r == 3) pc_mark = int'(pc);
      check($sformatf("tbl_en[%0d]", r),    {31'd0, enable_debug}, {31'd0, tbl[r].en});
      check($sformatf("tbl_halt[%0d]", r),  {31'd0, halted},       {31'd0, tbl[r].hlt});
      check($sformatf("tbl_steps[%0d]", r), {24'd0, steps_left},   tbl[r].steps);
      if (r == 8) check("step_pc_loads", int'(pc) - pc_mark, 3);
      finish_cyc(s);
    end

    // Breakpoint at 0x012, then resume past it.
    s = idle(); s.wr = 1; s.widx = 0; s.waddr = 'h012; s.wen = 1;
    tick(s);
    s = idle(); s.resume = 1;
    tick(s);
    run_to('h012, found);
    check("bp0_reached", {31'd0, found}, 1);
    if (found) begin
      check("bp0_freeze", {31'd0, enable_debug}, 1);
      finish_cyc(idle());
    end
    apply(idle());
    check("bp0_halted",  {31'd0, halted}, 1);
    check("bp0_hit",     {31'd0, bp_hit}, 1);
    check("bp0_hit_idx", {31'd0, hit_idx}, 0);
    check("bp0_pc_held", {23'd0, pc}, 'h012);
    finish_cyc(idle());
    s = idle(); s.resume = 1;
    tick(s);
    apply(idle());
    check("skip_no_rehit", {31'd0, enable_debug}, 0);
    check("skip_pc",       {23'd0, pc}, 'h012);
    finish_cyc(idle());
    apply(idle());
    check("past_bp_pc", {23'd0, pc}, 'h013);
    finish_cyc(idle());

    // Both slots on 0x020: slot 0 must win.
    s = idle(); s.wr = 1; s.widx = 0; s.waddr = 'h020; s.wen = 1;
    tick(s);
    s.widx = 1;
    tick(s);
    run_to('h020, found);
    check("bp_dual_reached", {31'd0, found}, 1);
    if (found) finish_cyc(idle());
    apply(idle());
    check("bp_dual_hit_idx", {31'd0, hit_idx}, 0);
    check("bp_dual_hit",     {31'd0, bp_hit}, 1);
    finish_cyc(idle());
    s = idle(); s.step = 1; s.cnt = 5;
    tick(s);
    apply(idle());
    check("step5_start", {24'd0, steps_left}, 5);
    finish_cyc(idle());
    s = idle(); s.halt = 1; s.resume = 1;
    tick(s);
    apply(idle());
    check("halt_beats_resume", {31'd0, halted}, 1);
    check("abort_steps",       {24'd0, steps_left}, 0);
    finish_cyc(idle());

    // Reset in the middle of a step.
    s = idle(); s.step = 1; s.cnt = 5;
    tick(s);
    s = idle(); s.stall = 1;
    apply(s);
    check("mid_step_steps", {24'd0, steps_left}, 5);
    reset = 1'b1;
    m_reset();
    #1;
    check("rst_en",    {31'd0, enable_debug}, 0);
    check("rst_halt",  {31'd0, halted}, 0);
    check("rst_steps", {24'd0, steps_left}, 0);
    check("rst_bphit", {31'd0, bp_hit}, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(idle());
    for (int k = 0; k < 40; k++) tick(idle());
    check("bps_cleared_run", {31'd0, halted}, 0);
    check("bps_cleared_pc",  {23'd0, pc}, 40);

    // Random traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      s = idle();
      s.halt   = ($urandom_range(0, 19) == 0);
      s.resume = ($urandom_range(0, 11) == 0);
      s.step   = ($urandom_range(0, 7) == 0);
      s.cnt    = $urandom_range(0, 6);
      s.stall  = ($urandom_range(0, 3) == 0);
      s.wr     = ($urandom_range(0, 15) == 0);
      s.widx   = $urandom_range(0, NUM_BP - 1);
      s.waddr  = (int'(pc) + $urandom_range(0, 12)) % (1 << PC_W);
      s.wen    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else tick(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
